// File: rtl/fifo_drain_module_pkg.sv
// Shared constants, FSM state encoding and byte-select helper for the FIFO drain controller.
package fifo_drain_module_pkg;

  localparam int unsigned FIFO_DEEP = 16;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LEFT_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_SEND_A  = 3'd3,
    ST_SEND_B  = 3'd4
  } state_e;

  // Select the high (hi=1) or low (hi=0) byte of a FIFO word.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[WORD_W-1:BYTE_W] : w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/fifo_drain_module.sv
// Read-side controller: pops one FIFO word at a time and sends it as two bytes
// over a valid/ready byte interface. All outputs come from flops or state decode.
module fifo_drain_module
  import fifo_drain_module_pkg::*;
#(
  parameter int unsigned FIFO_DEEP = fifo_drain_module_pkg::FIFO_DEEP,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [LEFT_W-1:0]   left_sig,
  input  logic [WORD_W-1:0]   fifo_read_data,
  output logic                read_req,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [WORD_W-1:0]   word_cnt
);

  localparam logic [LEFT_W-1:0] DEEP_L = LEFT_W'(FIFO_DEEP);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic                fifo_has_data;

  // Values above FIFO_DEEP are illegal and fall into the "empty" side of this compare.
  assign fifo_has_data = (left_sig < DEEP_L);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one word in flight at a time, left_sig only consulted in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable && fifo_has_data) state_d = ST_RD_REQ;
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_SEND_A;
      ST_SEND_A:  if (tx_ready) state_d = ST_SEND_B;
      ST_SEND_B:  if (tx_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    read_req = (state_q == ST_RD_REQ);
    busy     = (state_q != ST_IDLE);
  end

  // Datapath next values: capture word, stage bytes, count completed words.
  always_comb begin
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      ST_RD_WAIT: begin
        hold_d     = fifo_read_data;
        tx_data_d  = pick_byte(fifo_read_data, MSB_FIRST);
        tx_valid_d = 1'b1;
      end
      ST_SEND_A: begin
        if (tx_ready) begin
          tx_data_d = pick_byte(hold_q, !MSB_FIRST);
        end
      end
      ST_SEND_B: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          word_cnt_d = word_cnt_q + WORD_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_drain_module.sv
// Self-checking bench: two instances (MSB first / LSB first) share a behavioural
// FIFO; a word-level scoreboard predicts the byte stream and word count.
module tb_fifo_drain_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  left_sig = 5'd16;
  logic [15:0] fifo_read_data = '0;
  logic        tx_ready = 1'b0;

  logic        read_req_a, tx_valid_a, busy_a;
  logic [7:0]  tx_data_a;
  logic [15:0] word_cnt_a;
  logic        read_req_b, tx_valid_b, busy_b;
  logic [7:0]  tx_data_b;
  logic [15:0] word_cnt_b;

  fifo_drain_module #(.FIFO_DEEP(16), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .left_sig(left_sig),
    .fifo_read_data(fifo_read_data), .read_req(read_req_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready), .busy(busy_a), .word_cnt(word_cnt_a)
  );

  fifo_drain_module #(.FIFO_DEEP(16), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .left_sig(left_sig),
    .fifo_read_data(fifo_read_data), .read_req(read_req_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready), .busy(busy_b), .word_cnt(word_cnt_b)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural FIFO contents and word-level scoreboard.
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [4:0]  force_left = '0;
  bit          inflight = 0;
  bit          byte_idx = 0;
  logic [15:0] cnt_model = '0;
  int unsigned total_pops = 0;
  bit          rr_prev = 0;
  bit          stall_a = 0, stall_b = 0;
  logic [7:0]  prev_a = '0, prev_b = '0;
  bit          rand_ready = 0;

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO read port: registered data, valid the cycle after the pop strobe.
  always @(posedge clk) begin
    logic [15:0] tmp;
    if (read_req_a && fifo_q.size() > 0) begin
      tmp = fifo_q.pop_front();
      fifo_read_data <= tmp;
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: samples on the falling edge, predicts each byte from the word queue.
  always @(negedge clk) begin
    logic [15:0] w;
    logic [7:0]  exp_a, exp_b;
    bit          hs_a, hs_b;
    left_sig = (force_left != 0) ? force_left : 5'(16 - fifo_q.size());
    if (!rst_n) begin
      if (inflight) begin
        void'(exp_q.pop_front());
        inflight = 0;
      end
      byte_idx = 0; cnt_model = '0; rr_prev = 0; stall_a = 0; stall_b = 0;
    end else begin
      chk("word_cnt_msb", word_cnt_a, cnt_model);
      chk("word_cnt_lsb", word_cnt_b, cnt_model);
      if (stall_a) begin
        chk("stall_valid_msb", tx_valid_a, 1);
        chk("stall_data_msb", tx_data_a, prev_a);
      end
      if (stall_b) begin
        chk("stall_valid_lsb", tx_valid_b, 1);
        chk("stall_data_lsb", tx_data_b, prev_b);
      end
      if (read_req_a) begin
        chk("read_back_to_back", rr_prev, 0);
        chk("read_from_nonempty", fifo_q.size() != 0, 1);
        chk("single_outstanding", inflight, 0);
        inflight = 1;
        total_pops++;
      end
      hs_a = tx_valid_a && tx_ready;
      hs_b = tx_valid_b && tx_ready;
      if (hs_b && !hs_a) chk("lsb_unexpected_handshake", 1, 0);
      if (hs_a) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 1, 0);
        end else begin
          w = exp_q[0];
          exp_a = byte_idx ? w[7:0] : w[15:8];
          exp_b = byte_idx ? w[15:8] : w[7:0];
          chk("byte_msb", tx_data_a, exp_a);
          chk("valid_lsb", tx_valid_b, 1);
          chk("byte_lsb", tx_data_b, exp_b);
          if (byte_idx) begin
            void'(exp_q.pop_front());
            inflight = 0;
            cnt_model = cnt_model + 16'd1;
          end
          byte_idx = ~byte_idx;
        end
      end
      rr_prev = read_req_a;
      stall_a = tx_valid_a && !tx_ready;
      stall_b = tx_valid_b && !tx_ready;
      prev_a = tx_data_a;
      prev_b = tx_data_b;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_valid_a) begin ok = 1; break; end
    end
    chk("timeout_valid", ok, 1);
    step(1);
  endtask

  task automatic wait_not_busy(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_a) begin ok = 1; break; end
    end
    chk("timeout_idle", ok, 1);
    step(1);
  endtask

  task automatic wait_drained(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_a) begin ok = 1; break; end
    end
    chk("timeout_drain", ok, 1);
    step(1);
  endtask

  initial begin
    int unsigned p0;
    int          busy_cycles;

    // Reset and idle with an empty FIFO.
    #3 rst_n = 1'b0;
    step(2);
    chk("rst_valid", tx_valid_a, 0);
    chk("rst_data", tx_data_a, 8'h00);
    chk("rst_busy", busy_a, 0);
    chk("rst_read_req", read_req_a, 0);
    chk("rst_word_cnt", word_cnt_a, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tx_ready = 1'b1;
    p0 = total_pops;
    step(20);
    chk("empty_no_reads", total_pops - p0, 0);
    chk("empty_valid", tx_valid_a, 0);
    chk("empty_busy", busy_a, 0);
    chk("empty_word_cnt", word_cnt_a, 0);

    // Single word with the transmitter always ready: four busy cycles.
    p0 = total_pops;
    push(16'hA55A);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    step(1);
    chk("single_busy_cycles", busy_cycles, 4);
    chk("single_reads", total_pops - p0, 1);
    chk("single_word_cnt", word_cnt_a, 1);

    // Backpressure in both byte phases.
    tx_ready = 1'b0;
    p0 = total_pops;
    push(16'h1234);
    wait_valid(20);
    for (int i = 0; i < 7; i++) begin
      chk("bp_first_byte", tx_data_a, 8'h12);
      step(1);
    end
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_second_byte", tx_data_a, 8'h34);
      step(1);
    end
    tx_ready = 1'b1;
    wait_not_busy(20);
    chk("bp_reads", total_pops - p0, 1);

    // Full FIFO preloaded, drained under random backpressure.
    enable = 1'b0;
    for (int i = 1; i <= 16; i++) push(16'(i));
    step(2);
    p0 = total_pops;
    enable = 1'b1;
    rand_ready = 1;
    wait_drained(2000);
    rand_ready = 0;
    tx_ready = 1'b0;
    chk("drain_reads", total_pops - p0, 16);
    chk("drain_fifo_empty", fifo_q.size(), 0);
    chk("drain_word_cnt", word_cnt_a, 18);

    // Enable drop during the first byte of 0xBEEF with three words behind it.
    enable = 1'b0;
    push(16'hBEEF);
    for (int i = 0; i < 3; i++) push(16'($urandom));
    enable = 1'b1;
    wait_valid(20);
    enable = 1'b0;
    tx_ready = 1'b1;
    wait_not_busy(20);
    p0 = total_pops;
    step(10);
    chk("endrop_no_reads", total_pops - p0, 0);
    chk("endrop_remaining", fifo_q.size(), 3);
    chk("endrop_busy", busy_a, 0);
    enable = 1'b1;
    rand_ready = 1;
    wait_drained(500);
    rand_ready = 0;

    // Illegal left_sig above depth is treated as empty.
    enable = 1'b0;
    push(16'hC3A7);
    step(2);
    force_left = 5'($urandom_range(17, 31));
    enable = 1'b1;
    p0 = total_pops;
    step(10);
    chk("illegal_left_no_reads", total_pops - p0, 0);
    chk("illegal_left_busy", busy_a, 0);
    force_left = '0;
    tx_ready = 1'b1;
    wait_drained(100);

    // Reset pulsed in the second byte phase: in-flight word is dropped.
    enable = 1'b0;
    tx_ready = 1'b0;
    push(16'h5AC3);
    push(16'h9E71);
    enable = 1'b1;
    wait_valid(20);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    chk("pre_reset_valid", tx_valid_a, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_msb", tx_valid_a, 0);
    chk("async_rst_cnt_msb", word_cnt_a, 0);
    chk("async_rst_valid_lsb", tx_valid_b, 0);
    chk("async_rst_cnt_lsb", word_cnt_b, 0);
    chk("async_rst_busy", busy_a, 0);
    step(2);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    wait_drained(100);
    chk("post_reset_word_cnt", word_cnt_a, 1);

    // Randomized traffic: writes, enable and backpressure all random.
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 16 && $urandom_range(0, 2) == 0) push(16'($urandom));
      step(1);
    end
    enable = 1'b1;
    wait_drained(4000);
    rand_ready = 0;
    chk("final_fifo_empty", fifo_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
